// File: rtl/quad_encoder_emulator.sv
// Quadrature A/B encoder emulator: one full detent cycle per step,
// fed by a signed net-pending step counter behind a valid/ready port.
module quad_encoder_emulator #(
  parameter int DWELL       = 4,
  parameter int MAX_PENDING = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_step_valid,
  input  logic i_step_cw,
  output logic o_step_ready,
  input  logic i_flush,
  output logic o_phase_a,
  output logic o_phase_b,
  output logic o_done,
  output logic o_done_cw,
  output logic o_busy
);

  localparam int CNTW = $clog2(DWELL + 1);
  localparam int PW   = $clog2(MAX_PENDING + 1) + 1;

  localparam logic [CNTW-1:0] LAST = CNTW'(DWELL - 1);
  localparam logic [PW-1:0]   MAXU = PW'(MAX_PENDING);
  localparam logic signed [PW-1:0] P_ONE = 1;

  typedef enum logic [2:0] {
    IDLE, PH1, PH2, PH3, GAP
  } state_t;

  state_t state, state_n;
  logic dir, dir_n;
  logic [CNTW-1:0] cnt, cnt_n;
  logic signed [PW-1:0] pend, pend_n;
  logic [PW-1:0] mag;
  logic cnt_last, pend_nz, start, accept;
  logic a_n, b_n, done_n, done_cw_n;

  assign mag = pend[PW-1] ? $unsigned(-pend)
                          : $unsigned(pend);
  assign pend_nz = (pend != '0);
  assign cnt_last = (cnt == LAST);
  assign o_step_ready = !i_rst && (mag < MAXU);
  assign accept = i_step_valid && o_step_ready;
  assign o_busy = (state != IDLE) || pend_nz;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      dir       <= 1'b0;
      cnt       <= '0;
      pend      <= '0;
      o_phase_a <= 1'b0;
      o_phase_b <= 1'b0;
      o_done    <= 1'b0;
      o_done_cw <= 1'b0;
    end else begin
      state     <= state_n;
      dir       <= dir_n;
      cnt       <= cnt_n;
      pend      <= pend_n;
      o_phase_a <= a_n;
      o_phase_b <= b_n;
      o_done    <= done_n;
      o_done_cw <= done_cw_n;
    end
  end

  // Flush blocks a start so a cleared queue never launches a step.
  always_comb begin
    state_n = state;
    dir_n   = dir;
    start   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend_nz && !i_flush) begin
          state_n = PH1;
          start   = 1'b1;
        end
      end
      PH1: if (cnt_last) state_n = PH2;
      PH2: if (cnt_last) state_n = PH3;
      PH3: if (cnt_last) state_n = GAP;
      GAP: begin
        if (cnt_last) begin
          if (pend_nz && !i_flush) begin
            state_n = PH1;
            start   = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (start) dir_n = !pend[PW-1];
    if (state_n != state || state == IDLE)
      cnt_n = '0;
    else
      cnt_n = cnt + 1'b1;
  end

  always_comb begin
    pend_n = pend;
    if (i_flush) begin
      pend_n = '0;
    end else begin
      if (accept)
        pend_n = i_step_cw ? pend_n + P_ONE
                           : pend_n - P_ONE;
      if (start)
        pend_n = dir_n ? pend_n - P_ONE
                       : pend_n + P_ONE;
    end
  end

  always_comb begin
    a_n = 1'b0;
    b_n = 1'b0;
    unique case (1'b1)
      (state_n == PH1): begin
        a_n = dir_n;
        b_n = !dir_n;
      end
      (state_n == PH2): begin
        a_n = 1'b1;
        b_n = 1'b1;
      end
      (state_n == PH3): begin
        a_n = !dir_n;
        b_n = dir_n;
      end
      default: ;
    endcase
    done_n    = (state == PH3) && (state_n == GAP);
    done_cw_n = done_n && dir;
  end

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Randomised check of quad_encoder_emulator against a step-timeline
// model, plus a behavioural quadrature decoder on the outputs.
module tb_quad_encoder_emulator;

  localparam int D    = 2;
  localparam int MAXP = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v = 1'b0;
  logic cw = 1'b0;
  logic fl = 1'b0;
  logic rdy, pa, pb, done, done_cw, busy;

  quad_encoder_emulator #(.DWELL(D), .MAX_PENDING(MAXP)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_step_valid(v),
    .i_step_cw(cw),
    .o_step_ready(rdy),
    .i_flush(fl),
    .o_phase_a(pa),
    .o_phase_b(pb),
    .o_done(done),
    .o_done_cw(done_cw),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int m_p = 0;
  int m_t = -1;
  bit m_dir = 0;
  int m_acc = 0;

  int cyc_n = 0;
  int emu_cw = 0;
  int emu_ccw = 0;
  int dec_i = 0;
  int dec_acc = 0;
  int dec_cw = 0;
  int dec_ccw = 0;
  int dec_err = 0;

  int last_done = -1;
  int ndone = 0;
  bit saw_full = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int gidx(input logic [1:0] ab);
    case (ab)
      2'b00: return 0;
      2'b10: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  // A step is a 4*D-cycle timeline t; phase = t/D.
  task automatic model_edge(input bit iv, input bit icw,
                            input bit ifl);
    bit acc, last, go;
    acc  = iv && (iabs(m_p) < MAXP);
    last = (m_t == 4 * D - 1);
    go   = (m_t < 0 || last) && (m_p != 0) && !ifl;
    if (go) begin
      m_t   = 0;
      m_dir = (m_p > 0);
      m_p   = m_dir ? m_p - 1 : m_p + 1;
    end else if (last) begin
      m_t = -1;
    end else if (m_t >= 0) begin
      m_t++;
    end
    if (ifl) m_p = 0;
    else if (acc) begin
      m_p = icw ? m_p + 1 : m_p - 1;
      m_acc++;
    end
  endtask

  function automatic logic [1:0] model_ab();
    int ph;
    if (m_t < 0) return 2'b00;
    ph = m_t / D;
    case (ph)
      0: return m_dir ? 2'b10 : 2'b01;
      1: return 2'b11;
      2: return m_dir ? 2'b01 : 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic decode();
    int ni, d;
    ni = gidx({pa, pb});
    d = (ni - dec_i + 4) % 4;
    if (d == 2) dec_err++;
    else if (d == 1) dec_acc++;
    else if (d == 3) dec_acc--;
    dec_i = ni;
    if (ni == 0) begin
      if (dec_acc == 4) dec_cw++;
      else if (dec_acc == -4) dec_ccw++;
      else if (dec_acc != 0) dec_err++;
      dec_acc = 0;
    end
  endtask

  task automatic cyc(input bit iv, input bit icw, input bit ifl);
    logic [1:0] eab;
    bit edone;
    v  = iv;
    cw = icw;
    fl = ifl;
    @(posedge clk);
    model_edge(iv, icw, ifl);
    cyc_n++;
    #1;
    eab   = model_ab();
    edone = (m_t == 3 * D);
    chk("phase_ab", {30'd0, pa, pb}, {30'd0, eab});
    chk("done", {31'd0, done}, {31'd0, edone});
    chk("done_cw", {31'd0, done_cw},
        {31'd0, edone && m_dir});
    chk("ready", {31'd0, rdy},
        {31'd0, iabs(m_p) < MAXP});
    chk("busy", {31'd0, busy},
        {31'd0, (m_t >= 0) || (m_p != 0)});
    if (done) begin
      if (done_cw) emu_cw++;
      else emu_ccw++;
    end
    decode();
    v  = 1'b0;
    fl = 1'b0;
  endtask

  task automatic sat_step(input bit iv);
    cyc(iv, 1'b1, 1'b0);
    if (!rdy) saw_full = 1;
    if (done) begin
      if (last_done >= 0)
        chk("spacing", cyc_n - last_done, 4 * D);
      last_done = cyc_n;
      ndone++;
    end
  endtask

  logic [1:0] seq [1:7];
  int acc0;

  initial begin
    seq[1] = 2'b10; seq[2] = 2'b10;
    seq[3] = 2'b11; seq[4] = 2'b11;
    seq[5] = 2'b01; seq[6] = 2'b01;
    seq[7] = 2'b00;

    #12;
    chk("rst_ab", {30'd0, pa, pb}, 32'd0);
    chk("rst_ready", {31'd0, rdy}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_out_of_rst", {31'd0, rdy}, 32'd1);

    // Single CW step, explicit waveform.
    cyc(1'b1, 1'b1, 1'b0);
    chk("cw_accept_ab", {30'd0, pa, pb}, 32'd0);
    for (int i = 1; i <= 9; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (i <= 7)
        chk("cw_seq", {30'd0, pa, pb}, {30'd0, seq[i]});
      if (i == 7) begin
        chk("cw_done", {31'd0, done}, 32'd1);
        chk("cw_done_dir", {31'd0, done_cw}, 32'd1);
      end
      if (i == 8) chk("cw_busy8", {31'd0, busy}, 32'd1);
      if (i == 9) chk("cw_busy9", {31'd0, busy}, 32'd0);
    end

    // Single CCW step.
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("ccw_count", emu_ccw, 1);

    // Three CW then two CCW: one step survives cancellation.
    acc0 = emu_cw;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("cancel_cw", emu_cw - acc0, 1);
    chk("cancel_idle", {31'd0, busy}, 32'd0);

    // Saturation with valid held high.
    acc0 = m_acc;
    ndone = 0;
    last_done = -1;
    for (int i = 0; i < 60; i++) sat_step(1'b1);
    for (int i = 0; i < 1000 && busy; i++) sat_step(1'b0);
    chk("sat_full_seen", {31'd0, saw_full}, 32'd1);
    chk("sat_drained", {31'd0, busy}, 32'd0);
    chk("sat_done_eq_acc", ndone, m_acc - acc0);

    // Asynchronous reset in the middle of PH2.
    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("pre_rst_ph2", {30'd0, pa, pb}, 32'd3);
    #3;
    rst = 1'b1;
    #1;
    chk("async_ab", {30'd0, pa, pb}, 32'd0);
    chk("async_done", {31'd0, done}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_ready", {31'd0, rdy}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    m_p = 0;
    m_t = -1;
    dec_i = 0;
    dec_acc = 0;
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0);

    // Random traffic with occasional flush.
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 9) < 4, 1'($urandom_range(0, 1)),
          $urandom_range(0, 99) == 0);
    for (int i = 0; i < 1000 && busy; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("final_idle", {31'd0, busy}, 32'd0);

    chk("dec_cw_eq_done", dec_cw, emu_cw);
    chk("dec_ccw_eq_done", dec_ccw, emu_ccw);
    chk("dec_no_error", dec_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/quad_encoder_emulator.md
Name: quad_encoder_emulator

Overview:
- Generates quadrature phase A/B waveforms that emulate an incremental rotary encoder, one full detent cycle per commanded step.
- Intended for loopback testing of the team's synchronous quadrature decoder, and for driving encoder inputs of downstream logic from a command source.
- Step commands enter through a valid/ready handshake and accumulate in a signed net-pending counter. Opposite-direction commands cancel steps that are still pending.

Parameters:
- DWELL, 4, clock cycles each phase state is held (>=1); one step takes 4*DWELL cycles.
- MAX_PENDING, 15, magnitude limit of the net-pending step counter (>=1).

Ports:
- i_clk  input  1  system clock; all logic on posedge.
- i_rst  input  1  asynchronous, active-high reset.
- i_step_valid  input  1  step request present.
- i_step_cw  input  1  request direction: 1 = clockwise, 0 = counter-clockwise.
- o_step_ready  output  1  request is accepted on a posedge where valid && ready.
- i_flush  input  1  clears the pending counter; the step in progress still completes.
- o_phase_a  output  1  encoder phase A, registered.
- o_phase_b  output  1  encoder phase B, registered.
- o_done  output  1  one-cycle pulse when a step completes.
- o_done_cw  output  1  direction of the completed step; valid while o_done=1, else 0.
- o_busy  output  1  high when state != IDLE or pending != 0.

Behaviour:
- Reset (asynchronous, i_rst=1): state IDLE, pending P=0, dwell counter 0, o_phase_a=o_phase_b=0, o_done=0, o_done_cw=0. Outputs go to 0 immediately, including mid-step; no done pulse is issued for an aborted step.
- P is signed, range [-MAX_PENDING, +MAX_PENDING]. Width is clog2(MAX_PENDING+1)+1.
- o_step_ready = !i_rst && (|P| < MAX_PENDING). It is combinational from P only and does not depend on i_step_cw.
- An accepted CW request adds +1 to P; an accepted CCW request adds -1.
- Phase sequence, shown as (a,b):
  - CW: 00 -> 10 -> 11 -> 01 -> 00.
  - CCW: 00 -> 01 -> 11 -> 10 -> 00.
  - Exactly one output bit changes per transition. Rest level is 00.
  - The decoder counts a step as CW when A leads, and raises its count pulse on the return to 00.
- States: IDLE, PH1, PH2, PH3, GAP. The dwell counter is reloaded on every state entry.
  - IDLE: outputs 00. If P != 0 at a posedge, enter PH1 and latch dir = (P > 0).
  - PH1, PH2, PH3: drive phases 1, 2, 3 of the latched direction for DWELL cycles each, then advance.
  - PH3 -> GAP: outputs return to 00. o_done=1 and o_done_cw=dir for exactly that first GAP cycle.
  - GAP: hold 00 for DWELL cycles (minimum spacing between steps). At the end, if P != 0, go directly to PH1 with a new dir; otherwise go to IDLE.
- Step start: on the PH1 entry edge, P moves one toward zero. The dequeue delta and the accept delta are summed in the same cycle, so simultaneous accept and start are lossless.
- Latency: a request accepted at edge k with P=0 in IDLE sets P=1; the first output bit changes at edge k+1.
- Cancellation: opposite-direction requests reduce |P| and may flip its sign. The step in progress is never cancelled or reversed.
- i_flush: P <= 0 on the edge. A request accepted on the same edge is discarded. Flush has priority over start, so no new step starts on a flush edge.
- Back-to-back steps with continuous P != 0 give a strict period of 4*DWELL cycles.
- P never exceeds ±MAX_PENDING: ready is low at the limit. A start on the same edge frees a slot only on the following cycle.

Test Plan:
- DWELL=2, one CW request from IDLE -> (a,b) = 10,10,11,11,01,01,00. o_done=1 with o_done_cw=1 on the first 00 cycle. o_busy falls after GAP, 9 cycles after acceptance.
- One CCW request -> 01,11,10,00 with each phase held for DWELL cycles. o_done_cw=0. No cycle has both bits changing.
- Three CW requests on consecutive cycles from IDLE, then two CCW requests -> exactly one CW done pulse; P returns to 0; back to IDLE.
- MAX_PENDING=15, valid held with CW=1 during the first step -> ready drops when P=15. The total number of done pulses equals the number of accepted requests. Steps are spaced by 4*DWELL cycles.
- Assert i_rst mid-PH2 -> outputs 00 in the same cycle (asynchronous), P=0, no o_done. The first step after reset release is normal.
- Loopback into the quadrature decoder with random CW/CCW requests and random valid gaps, DWELL=1..5 -> decoder CW/CCW counts equal emulator done pulses per direction, and the decoder never enters its error state.
